data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Memory-side responder for the pipeline's data-memory port.
- Accepts word reads and writes issued on mem_ren/mem_wen/mem_addr/mem_dout.
- Returns read data on mem_din after a programmable number of wait states, holding the pipeline via mem_stall until each access completes.
- Sits between the datapath MEM stage and a synchronous single-port word RAM, which is internal to this block.

Parameters:
ADDR_BITS, 10, word-address width; RAM depth = 2^ADDR_BITS words of 32 bits
LATENCY, 2, wait cycles between request capture and access; legal range 1..15

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  asynchronous, active-high reset
mem_ren  input  1  read request from MEM stage
mem_wen  input  1  write request from MEM stage
mem_addr  input  32  byte address; word index = mem_addr[ADDR_BITS+1:2]
mem_dout  input  32  write data from requester
mem_din  output  32  read data returned to requester
mem_stall  output  1  high while a request is pending and not yet answered
mem_ack  output  1  one-cycle completion strobe
mem_err  output  1  error flag for the completing access, valid with mem_ack

Behaviour:
Reset values (asynchronous, immediate):
- state = IDLE; wait counter = 0; mem_din = 0; mem_ack = 0; mem_err = 0.
- mem_stall follows its combinational definition.
- RAM contents are not cleared by reset.

Request detection:
- req = mem_ren | mem_wen.
- mem_stall = req && (state != DONE), combinational.

FSM, state IDLE:
- If req is sampled at an edge: latch op, addr and wdata; load counter = LATENCY-1; go to WAIT.
- Otherwise stay in IDLE.

FSM, state WAIT (counter != 0):
- Decrement the counter each edge.

FSM, state WAIT (counter == 0):
- Perform the access on this edge.
- Write: RAM[idx] <= latched wdata.
- Read: mem_din <= RAM[idx].
- Latch the error result; go to DONE.

FSM, state DONE:
- mem_ack = 1; mem_err = latched error; mem_stall = 0.
- Next edge always returns to IDLE.
- A request still present in that IDLE cycle is treated as a new request.

Timing:
- Request first sampled at edge T gives mem_ack high during cycle T+LATENCY+1.
- mem_stall is high from the first cycle of the request until that cycle.

Data hold rules:
- mem_din holds its value until the next successful read completes.
- Writes and errored accesses leave mem_din unchanged, except out-of-range reads (see below).

Latching rules:
- Operands are captured only in IDLE.
- Changes to mem_addr, mem_dout, mem_ren or mem_wen during WAIT are ignored.
- If req is dropped mid-transaction, the captured access still completes and acks.

Error conditions (mem_err = 1 with mem_ack):
- Misaligned: addr[1:0] != 0. Access suppressed; no write, mem_din unchanged.
- Out of range: addr[31:ADDR_BITS+2] != 0. Write suppressed; a read returns mem_din = 32'h0.
- Both mem_ren and mem_wen at capture: the write is performed if the address is legal, no read occurs, and mem_err = 1.
- Several conditions may apply at once; mem_err is a single OR of all of them.

Reset mid-operation:
- FSM is forced to IDLE asynchronously.
- A pending write captured but not yet performed is discarded; RAM is unchanged.

Other:
- No outstanding-request queue; exactly one access is in flight.
- mem_ack and mem_err are registered outputs, low in every state except DONE.

Test Plan:
1. LATENCY=2: write addr 0x10 data 0xDEADBEEF, then read 0x10 -> each request acks 3 cycles after first sample with stall high for 3 cycles; read gives mem_din = 0xDEADBEEF, mem_err = 0.
2. Back-to-back: ren held high across ack at 0x0, then addr changed to 0x4 in the cycle after DONE -> two distinct acks, no lost or duplicated access, mem_din updates to RAM[1].
3. Misaligned read 0x13 after mem_din = 0x12345678 -> mem_ack with mem_err = 1, mem_din stays 0x12345678. Out-of-range write to 0x1000 (ADDR_BITS=10) -> mem_err = 1 and RAM[0] unchanged.
4. mem_ren and mem_wen both high, addr 0x8, dout 0xA5A5A5A5 -> mem_err = 1; a subsequent read of 0x8 returns 0xA5A5A5A5.
5. rst asserted during WAIT of a write to 0x20 -> outputs zero immediately, FSM in IDLE; a later read of 0x20 returns the pre-write value.
6. LATENCY=1 and LATENCY=15: single read -> ack at T+2 and T+16 respectively. Changing mem_addr during WAIT does not alter the returned data.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder: wait-state memory responder with an internal word RAM, stall/ack handshake and error reporting.
module data_mem_responder #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        mem_stall,
  output logic        mem_ack,
  output logic        mem_err
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  localparam logic [3:0] LOAD = 4'(LATENCY - 1);
  state_t state, state_n;
  logic [3:0] cnt;
  logic op_r, op_w, req, fire, mis, oor;
  logic [31:0] addr_q, wdata_q;
  logic [ADDR_BITS-1:0] idx;
  logic [31:0] ram [2**ADDR_BITS];
  always_comb begin
    req = mem_ren | mem_wen;
    mem_stall = req && state != DONE;
    fire = state == WAIT && cnt == '0;
    idx = addr_q[ADDR_BITS+1:2];
    mis = |addr_q[1:0];
    oor = |addr_q[31:ADDR_BITS+2];
    state_n = state == IDLE ? (req ? WAIT : IDLE) : state == WAIT ? (fire ? DONE : WAIT) : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      mem_din <= '0;
      mem_ack <= 1'b0;
      mem_err <= 1'b0;
      op_r    <= 1'b0;
      op_w    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_n;
      mem_ack <= fire;
      mem_err <= fire && (mis || oor || (op_r && op_w));
      if (state == IDLE && req) begin
        op_r    <= mem_ren;
        op_w    <= mem_wen;
        addr_q  <= mem_addr;
        wdata_q <= mem_dout;
        cnt     <= LOAD;
      end else if (state == WAIT && !fire) cnt <= cnt - 1'b1;
      // a combined read+write is treated as a write only; misaligned reads leave mem_din alone
      if (fire && op_r && !op_w && !mis) mem_din <= oor ? '0 : ram[idx];
    end
  always_ff @(posedge clk)
    if (fire && op_w && !mis && !oor) ram[idx] <= wdata_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: three independent responders (LATENCY 2, 1, 15) checked against an array-based model.
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic        ren [3];
  logic        wen [3];
  logic [31:0] addr [3];
  logic [31:0] wd [3];
  logic [31:0] din [3];
  logic        stall [3];
  logic        ack [3];
  logic        err [3];
  int lat [3] = '{2, 1, 15};
  logic [31:0] mram [3][1024];
  logic [31:0] mdin [3];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_BITS(10), .LATENCY(2)) dut0 (
    .clk(clk), .rst(rst), .mem_ren(ren[0]), .mem_wen(wen[0]), .mem_addr(addr[0]),
    .mem_dout(wd[0]), .mem_din(din[0]), .mem_stall(stall[0]), .mem_ack(ack[0]), .mem_err(err[0]));
  data_mem_responder #(.ADDR_BITS(10), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .mem_ren(ren[1]), .mem_wen(wen[1]), .mem_addr(addr[1]),
    .mem_dout(wd[1]), .mem_din(din[1]), .mem_stall(stall[1]), .mem_ack(ack[1]), .mem_err(err[1]));
  data_mem_responder #(.ADDR_BITS(10), .LATENCY(15)) dut2 (
    .clk(clk), .rst(rst), .mem_ren(ren[2]), .mem_wen(wen[2]), .mem_addr(addr[2]),
    .mem_dout(wd[2]), .mem_din(din[2]), .mem_stall(stall[2]), .mem_ack(ack[2]), .mem_err(err[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input int i, input bit scramble);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (!ack[i]) begin
        chk("stall_wait", 32'(stall[i]), 32'd1);
        if (scramble) begin
          addr[i] = $urandom;
          wd[i] = $urandom;
        end
      end
    end while (!ack[i] && n < 40);
    chk("latency", n, lat[i] + 1);
    chk("stall_ack", 32'(stall[i]), 32'd0);
  endtask

  task automatic done_check(input int i, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    bit mis, oor;
    mis = a[1:0] != 2'b0;
    oor = a[31:12] != 20'b0;
    chk("ack", 32'(ack[i]), 32'd1);
    chk("err", 32'(err[i]), 32'(mis | oor | (r & w)));
    if (w && !mis && !oor) mram[i][a[11:2]] = d;
    if (r && !w && !mis) mdin[i] = oor ? 32'h0 : mram[i][a[11:2]];
    chk("din", din[i], mdin[i]);
  endtask

  task automatic access(input int i, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d, input bit scramble);
    ren[i] = r;
    wen[i] = w;
    addr[i] = a;
    wd[i] = d;
    #1;
    chk("stall_req", 32'(stall[i]), 32'd1);
    wait_ack(i, scramble);
    done_check(i, r, w, a, d);
    ren[i] = 1'b0;
    wen[i] = 1'b0;
    @(posedge clk);
    #1;
    chk("ack_clear", 32'(ack[i]), 32'd0);
    chk("err_clear", 32'(err[i]), 32'd0);
  endtask

  initial begin
    int i, k, sel, word;
    logic [31:0] a;
    for (int j = 0; j < 3; j++) begin
      ren[j] = 1'b0;
      wen[j] = 1'b0;
      addr[j] = '0;
      wd[j] = '0;
      mdin[j] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int j = 0; j < 3; j++) begin
      chk("rst_din", din[j], 32'h0);
      chk("rst_ack", 32'(ack[j]), 32'd0);
      chk("rst_err", 32'(err[j]), 32'd0);
      chk("rst_stall", 32'(stall[j]), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int j = 0; j < 3; j++)
      for (int w = 0; w < 16; w++) access(j, 1'b0, 1'b1, 32'(w * 4), $urandom, 1'b0);
    access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    chk("t1_din", din[0], 32'hDEADBEEF);
    ren[0] = 1'b1;
    addr[0] = 32'h0;
    #1;
    chk("btb_stall0", 32'(stall[0]), 32'd1);
    wait_ack(0, 1'b0);
    done_check(0, 1'b1, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    chk("btb_gap_ack", 32'(ack[0]), 32'd0);
    addr[0] = 32'h4;
    #1;
    chk("btb_stall1", 32'(stall[0]), 32'd1);
    wait_ack(0, 1'b0);
    done_check(0, 1'b1, 1'b0, 32'h4, 32'h0);
    ren[0] = 1'b0;
    @(posedge clk);
    #1;
    chk("btb_no_dup", 32'(ack[0]), 32'd0);
    access(0, 1'b0, 1'b1, 32'h14, 32'h12345678, 1'b0);
    access(0, 1'b1, 1'b0, 32'h14, 32'h0, 1'b0);
    access(0, 1'b1, 1'b0, 32'h13, 32'h0, 1'b0);
    chk("mis_hold", din[0], 32'h12345678);
    access(0, 1'b0, 1'b1, 32'h1000, 32'hFFFF0000, 1'b0);
    access(0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    access(0, 1'b1, 1'b0, 32'h1004, 32'h0, 1'b0);
    chk("oor_read_zero", din[0], 32'h0);
    access(0, 1'b1, 1'b1, 32'h8, 32'hA5A5A5A5, 1'b0);
    access(0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0);
    chk("both_wrote", din[0], 32'hA5A5A5A5);
    wen[0] = 1'b1;
    addr[0] = 32'h20;
    wd[0] = 32'hCAFEF00D;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_din", din[0], 32'h0);
    chk("mid_rst_ack", 32'(ack[0]), 32'd0);
    chk("mid_rst_err", 32'(err[0]), 32'd0);
    wen[0] = 1'b0;
    for (int j = 0; j < 3; j++) mdin[j] = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    access(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
    access(1, 1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
    access(2, 1'b1, 1'b0, 32'h14, 32'h0, 1'b1);
    access(2, 1'b0, 1'b1, 32'h18, 32'h600DF00D, 1'b1);
    access(2, 1'b1, 1'b0, 32'h18, 32'h0, 1'b1);
    repeat (40) begin
      i = $urandom_range(2, 0);
      k = $urandom_range(3, 1);
      sel = $urandom_range(9, 0);
      word = $urandom_range(15, 0);
      a = sel < 7 ? 32'(word * 4) : sel == 7 ? 32'(word * 4 + $urandom_range(3, 1))
        : sel == 8 ? (32'h1000 | 32'(word * 4)) : ($urandom | 32'h80000000);
      access(i, k[0], k[1], a, $urandom, bit'($urandom_range(1, 0)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
